// File: rtl/mux_n1_rr_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the N:1 registered selector.
//   - mode_e   : selection mode encoding carried on the 2-bit mode port
//   - wrap_inc : increment modulo n, used for the scan/round-robin pointer
// ---------------------------------------------------------------------------
package mux_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED = 2'b00,
        MODE_SCAN  = 2'b01,
        MODE_RR    = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    // Returns (v + 1) mod n for v in 0..n-1; n == 1 always yields 0.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/mux_n1_rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational rotate-priority search. Returns the first requesting index
//   found when scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//
//   Ports
//     req       in   N   request vector
//     ptr       in   CW  highest-priority index (0..N-1)
//     gnt_valid out  1   at least one request is set
//     gnt_idx   out  CW  winning index (0 when gnt_valid is 0)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N  = 8,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic          gnt_valid,
    output logic [CW-1:0] gnt_idx
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_rot;

    // Duplicating the request vector and shifting by ptr puts the request of
    // channel (ptr + k) mod N at bit k, so the search below needs only
    // constant bit indices.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl >> ptr;

    always_comb begin
        int unsigned idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!gnt_valid && req_rot[k]) begin
                idx = 32'(ptr) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                gnt_valid = 1'b1;
                gnt_idx   = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/mux_n1_rr.sv
// ---------------------------------------------------------------------------
// mux_n1_rr
//   N-channel, W-bit registered selector with valid/ready on every input and
//   on the output. Modes: fixed (sel), scan (wait on ptr in order),
//   round-robin (rotating priority among requesters), reserved (no grants).
//
//   Ports
//     clk        in   1    clock, rising edge
//     rst        in   1    synchronous active-high reset
//     mode       in   2    00 fixed, 01 scan, 10 round-robin, 11 reserved
//     sel        in   CW   channel index for fixed mode (>= N never grants)
//     in_data    in   N*W  channel i at bits [i*W +: W]
//     in_valid   in   N    per-channel valid
//     in_ready   out  N    per-channel ready, at most one bit set
//     out_data   out  W    registered selected data
//     out_ch     out  CW   channel that produced out_data
//     out_valid  out  1    output register holds a word
//     out_ready  in   1    consumer accept
// ---------------------------------------------------------------------------
module mux_n1_rr
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int W  = 8,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic [CW-1:0]   sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic [CW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [CW-1:0] ptr;
    logic          load_ok;
    logic          sel_hit;
    logic          ptr_hit;
    logic          rr_valid;
    logic [CW-1:0] rr_idx;
    logic          g_valid;
    logic [CW-1:0] g_idx;
    logic [W-1:0]  g_data;
    logic          xfer;
    logic          ptr_adv;

    rr_arbiter #(.N(N)) u_arb (
        .req       (in_valid),
        .ptr       (ptr),
        .gnt_valid (rr_valid),
        .gnt_idx   (rr_idx)
    );

    // Output register can take a word when empty or being drained now.
    assign load_ok = !out_valid || out_ready;

    // Valid lookups by comparison against every legal index, so a sel value
    // of N or above simply matches nothing.
    always_comb begin
        sel_hit = 1'b0;
        ptr_hit = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (sel == CW'(i)) begin
                sel_hit = in_valid[i];
            end
            if (ptr == CW'(i)) begin
                ptr_hit = in_valid[i];
            end
        end
    end

    // Grant candidate for the current mode.
    always_comb begin
        g_valid = 1'b0;
        g_idx   = '0;
        ptr_adv = 1'b0;
        case (mode_e'(mode))
            MODE_FIXED: begin
                g_valid = sel_hit;
                g_idx   = sel;
            end
            MODE_SCAN: begin
                g_valid = ptr_hit;
                g_idx   = ptr;
                ptr_adv = 1'b1;
            end
            MODE_RR: begin
                g_valid = rr_valid;
                g_idx   = rr_idx;
                ptr_adv = 1'b1;
            end
            default: begin
                g_valid = 1'b0;
            end
        endcase
    end

    // A granted channel is always valid, so offering ready is the transfer.
    assign xfer = !rst && g_valid && load_ok;

    always_comb begin
        in_ready = '0;
        g_data   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (g_idx == CW'(i)) begin
                in_ready[i] = xfer;
                g_data      = in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= g_data;
                out_ch    <= g_idx;
                if (ptr_adv) begin
                    ptr <= CW'(wrap_inc(32'(g_idx), N));
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_n1_rr.sv
module tb_mux_n1_rr;

    logic clk = 1'b0;
    logic rst;
    logic out_ready;

    // Instance A: N=8, W=8
    logic [1:0]  a_mode;
    logic [2:0]  a_sel;
    logic [63:0] a_data;
    logic [7:0]  a_valid;
    logic [7:0]  a_rdy;
    logic [7:0]  a_odata;
    logic [2:0]  a_och;
    logic        a_ov;

    // Instance B: N=10, W=8 (non-power-of-two, sel beyond N)
    logic [1:0]  b_mode;
    logic [3:0]  b_sel;
    logic [79:0] b_data;
    logic [9:0]  b_valid;
    logic [9:0]  b_rdy;
    logic [7:0]  b_odata;
    logic [3:0]  b_och;
    logic        b_ov;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model state
    int          pa, pb;
    logic        ova, ovb;
    logic [7:0]  oda, odb;
    int          ocha, ochb;
    logic [63:0] era, erb;

    always #5 clk = ~clk;

    mux_n1_rr #(.N(8), .W(8)) dut_a (
        .clk(clk), .rst(rst), .mode(a_mode), .sel(a_sel),
        .in_data(a_data), .in_valid(a_valid), .in_ready(a_rdy),
        .out_data(a_odata), .out_ch(a_och), .out_valid(a_ov),
        .out_ready(out_ready)
    );

    mux_n1_rr #(.N(10), .W(8)) dut_b (
        .clk(clk), .rst(rst), .mode(b_mode), .sel(b_sel),
        .in_data(b_data), .in_valid(b_valid), .in_ready(b_rdy),
        .out_data(b_odata), .out_ch(b_och), .out_valid(b_ov),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Grant chosen by the selection rules, -1 for none.
    function automatic int model_grant(input logic [1:0] md, input int s,
                                       input logic [63:0] v, input int p, input int n);
        case (md)
            2'b00: return (s < n && v[s]) ? s : -1;
            2'b01: return v[p] ? p : -1;
            2'b10: begin
                for (int k = 0; k < n; k++) begin
                    if (v[(p + k) % n]) return (p + k) % n;
                end
                return -1;
            end
            default: return -1;
        endcase
    endfunction

    // Advance the model by one clock; returns the ready vector expected
    // before the edge and leaves the post-edge state in p/ov/od/och.
    task automatic model_cycle(input int n, input logic [1:0] md, input int s,
                               input logic [63:0] v, input logic [127:0] d,
                               input logic ordy, input logic r,
                               inout int p, inout logic ov, inout logic [7:0] od,
                               inout int och, output logic [63:0] rdy);
        int g;
        rdy = '0;
        if (r) begin
            p = 0; ov = 1'b0; od = '0; och = 0;
        end else begin
            g = model_grant(md, s, v, p, n);
            if (g >= 0 && (!ov || ordy)) begin
                rdy[g] = 1'b1;
                od  = d[g*8 +: 8];
                och = g;
                ov  = 1'b1;
                if (md == 2'b01 || md == 2'b10) p = (g + 1) % n;
            end else if (ov && ordy) begin
                ov = 1'b0;
            end
        end
    endtask

    task automatic step(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            model_cycle(8, a_mode, int'(a_sel), 64'(a_valid), 128'(a_data),
                        out_ready, rst, pa, ova, oda, ocha, era);
            check("a_in_ready", 80'(a_rdy), 80'(era));
            model_cycle(10, b_mode, int'(b_sel), 64'(b_valid), 128'(b_data),
                        out_ready, rst, pb, ovb, odb, ochb, erb);
            check("b_in_ready", 80'(b_rdy), 80'(erb));
            @(posedge clk);
            #1;
            check("a_out_valid", 80'(a_ov), 80'(ova));
            check("a_out_data",  80'(a_odata), 80'(oda));
            check("a_out_ch",    80'(a_och), 80'(ocha));
            check("b_out_valid", 80'(b_ov), 80'(ovb));
            check("b_out_data",  80'(b_odata), 80'(odb));
            check("b_out_ch",    80'(b_och), 80'(ochb));
        end
    endtask

    initial begin
        pa = 0; pb = 0; ova = 0; ovb = 0; oda = 0; odb = 0; ocha = 0; ochb = 0;
        rst = 1'b1; out_ready = 1'b1;
        a_mode = 2'b00; a_sel = '0; a_data = '0; a_valid = '0;
        b_mode = 2'b00; b_sel = '0; b_data = '0; b_valid = '0;
        for (int i = 0; i < 8; i++)  a_data[i*8 +: 8] = 8'hA0 + 8'(i);
        for (int i = 0; i < 10; i++) b_data[i*8 +: 8] = 8'hB0 + 8'(i);
        step(2);
        rst = 1'b0;

        // Round-robin fairness across all eight channels
        a_mode = 2'b10; a_valid = 8'hFF;
        step(10);

        // Round-robin skipping: take channel 2 to leave ptr at 3, then 7,2,7
        a_valid = 8'h04;
        step(1);
        a_valid = 8'h84;
        step(3);

        // Fixed mode on channel 5 with toggling valid; B on last channel
        a_mode = 2'b00; a_sel = 3'd5;
        b_mode = 2'b00; b_sel = 4'd9; b_valid = '1;
        for (int i = 0; i < 6; i++) begin
            a_valid = (i % 2 == 0) ? 8'h20 : 8'hDF;
            a_data[40 +: 8] = 8'($urandom);
            step(1);
        end
        // sel beyond N on B never grants
        b_sel = 4'd12;
        step(3);

        // Scan waits on channel 0 while only channel 1 is valid
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        a_mode = 2'b01; a_valid = 8'h02;
        step(4);
        a_valid = 8'h03;
        step(1);
        a_valid = 8'h01;
        step(3);

        // Backpressure holding 8'h5A, then back-to-back with no bubble
        a_mode = 2'b00; a_sel = 3'd3; a_valid = 8'h08; a_data[24 +: 8] = 8'h5A;
        step(1);
        out_ready = 1'b0; a_data[24 +: 8] = 8'h77;
        step(4);
        out_ready = 1'b1;
        step(2);

        // Reset while a word is buffered; round-robin restarts at channel 0
        a_mode = 2'b10; a_valid = 8'hFF;
        step(3);
        rst = 1'b1; out_ready = 1'b0;
        step(1);
        rst = 1'b0; out_ready = 1'b1;
        step(3);

        // Reserved mode grants nothing
        a_mode = 2'b11; b_mode = 2'b11; b_valid = '1;
        step(3);

        // Randomised traffic on both instances
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) a_mode = 2'($urandom);
            if ($urandom_range(0, 15) == 0) b_mode = 2'($urandom);
            a_sel     = 3'($urandom);
            b_sel     = 4'($urandom);
            a_valid   = 8'($urandom);
            b_valid   = 10'($urandom);
            a_data    = {$urandom, $urandom};
            b_data    = {16'($urandom), $urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 63) == 0);
            step(1);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mux_n1_rr.md
# mux_n1_rr

Parametrised N-channel, W-bit registered selector with valid/ready handshaking on every input and on the output. Three selection modes: fixed (software select), scan (visit channels in order, waiting on each), and round-robin (fair arbitration among requesting channels). Sits between multiple producer streams and a single consumer; generalises the combinational 8:1 select to arbitrary width and channel count, with a pipelined output stage and backpressure.

## Interface
- N, default 8: number of input channels, 1..64, need not be a power of two.
- W, default 8: data width per channel, >= 1.
- CW, derived as max(1, $clog2(N)); not user-set.

- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- mode  in  2  00 fixed, 01 scan, 10 round-robin, 11 reserved (no grants).
- sel  in  CW  channel index used in fixed mode.
- in_data  in  N*W  channel i occupies bits [i*W +: W].
- in_valid  in  N  per-channel valid.
- in_ready  out  N  per-channel ready, at most one bit set.
- out_data  out  W  registered selected data.
- out_ch  out  CW  index of the channel that produced out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts when out_valid && out_ready.

## Operation
- Output register is a single entry. It can load when it is empty or being drained this cycle: load_ok = !out_valid || out_ready.
- Grant candidate g, computed combinationally each cycle:
  - Fixed: g = sel when sel < N and in_valid[sel]; otherwise none. sel >= N never grants.
  - Scan: g = ptr when in_valid[ptr]; otherwise none. Scan does not skip idle channels.
  - Round-robin: g = first i with in_valid[i], searching ptr, ptr+1, …, N-1, 0, …, ptr-1; none if no bit is set.
  - Reserved mode: none.
- in_ready[g] = load_ok when a grant exists; all other in_ready bits are 0. in_ready never depends on in_valid of any channel other than those examined by the current mode.
- Transfer on channel g when in_valid[g] && in_ready[g]:
  - out_data <= in_data[g]
  - out_ch <= g
  - out_valid <= 1
- When out_ready && out_valid and no transfer occurs, out_valid <= 0. out_data and out_ch hold their values.
- ptr (CW bits, range 0..N-1) updates only on a transfer:
  - Scan: ptr <= g+1.
  - Round-robin: ptr <= g+1.
  - Fixed: ptr unchanged.
  - All increments wrap from N-1 to 0.
- Mode or sel changes take effect on the next cycle's grant decision. ptr is preserved across mode changes. An in-flight output word is unaffected.
- N = 1: ptr is constant 0, and all modes except reserved reduce to channel 0.

## Timing
- Reset values: out_valid 0, out_data 0, out_ch 0, ptr 0, in_ready all 0 while rst is high.
- Latency is 1 cycle from input transfer to out_valid. Throughput is 1 word per cycle with out_ready held high.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready bits are 0 and the output holds stable.
- Simultaneous drain and load in the same cycle: out_valid stays 1 and new data appears the next cycle, with no bubble.
- rst asserted mid-operation: the buffered word is discarded, out_valid is 0 the next cycle, and ptr returns to 0.

## Structure
- Package mux_pkg:
  - Mode localparams MODE_FIXED=2'b00, MODE_SCAN=2'b01, MODE_RR=2'b10, MODE_RSVD=2'b11.
  - Function for the wrap-around increment modulo N.
- Sub-module rr_arbiter (parameter N): inputs req[N-1:0] and ptr; outputs gnt_valid and gnt_idx. Purely combinational rotate-priority search, reused by the round-robin path.
- Top level: mode decode, the grant mux, the output register and the ptr register.

## Test plan
- Round-robin fairness: N=8, W=8, mode=10, out_ready=1, all in_valid=1, in_data[i]=8'hA0+i. Expect out_ch sequence 0,1,2,…,7,0 on consecutive cycles after a 1-cycle latency, with one in_ready bit set per cycle.
- Round-robin skipping: in_valid=8'b1000_0100, ptr=3. Expect grant to channel 7, then channel 2, then 7, with data matching.
- Fixed mode: mode=00, sel=5, in_valid[5] toggling. Expect out_data=in_data[5] only on cycles following in_valid[5]=1. With sel=9 and N=10, expect grant on channel 9. With sel=12 and N=10, expect no grant ever.
- Scan waits: mode=01, only channel 1 valid, ptr=0. Expect in_ready all 0 for the whole run and no output; raising in_valid[0] produces a transfer from channel 0, then the block waits on channel 1.
- Backpressure: out_ready=0 for 4 cycles after a transfer of 8'h5A. Expect out_valid=1 and out_data=8'h5A held, and in_ready=0 throughout. With out_ready=1 and a waiting requester, expect back-to-back transfer with no bubble.
- Reset mid-stream: assert rst while out_valid=1. Next cycle expect out_valid=0, out_data=0, and round-robin restarts from channel 0.
